fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage upstream of the branch/forwarding controller: owns the fetch PC, drives the
//  instruction-memory request/response handshake and holds the IF/ID register whose pc/inst feed the
//  controller. Consumes controller outputs (stall NOP, prediction, new_pc) for decode-time redirect and
//  EX/MEM resolution for misprediction recovery. One fetch outstanding at a time.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC loaded on reset
//  NOP_INST  32'h0000_0013  addi x0,x0,0 placed in IF/ID when empty/flushed
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  imem_req       out  1   fetch request valid
//  imem_addr      out  32  fetch address (== fetch_pc while imem_req)
//  imem_ready     in   1   request accepted when imem_req & imem_ready
//  imem_valid     in   1   response valid (>=1 cycle after acceptance)
//  imem_rdata     in   32  fetched instruction
//  stall          in   1   controller NOP (load-use): hold IF/ID and fetch_pc
//  prediction     in   1   controller predict-taken for IF/ID inst
//  new_pc         in   32  controller target for IF/ID inst
//  res_valid      in   1   control instruction resolving in EX/MEM this cycle
//  res_pred       in   1   prediction that instruction was fetched with
//  res_taken      in   1   actual outcome
//  res_pc         in   32  PC of resolving instruction
//  res_target     in   32  actual taken target
//  if_id_pc       out  32  IF/ID PC (controller pc)
//  if_id_inst     out  32  IF/ID instruction (controller inst)
//  if_id_valid    out  1   IF/ID holds a real instruction
//  flush          out  1   1-cycle pulse: younger stages must squash
//  mispred_cnt    out  32  mispredict count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-fetch): fetch_pc=RESET_PC, state=S_BOOT, imem_req=0, if_id_pc=0,
//   if_id_inst=NOP_INST, if_id_valid=0, flush=0, skid empty, mispred_cnt=0. Late responses dropped.
//  States: S_BOOT -> S_ISSUE (1 cycle after rst low). S_ISSUE: imem_req=1; on accept -> S_WAIT.
//   S_WAIT: imem_req=0; on imem_valid deliver response, fetch_pc+=4, -> S_ISSUE. S_DROP: imem_req=0;
//   on imem_valid discard response, -> S_ISSUE.
//  Deliver: stall=0 and skid empty -> IF/ID<= {fetch_pc, imem_rdata, 1}; else -> skid (1 entry).
//   Skid full: no new issue (stay S_ISSUE with imem_req=0). Skid drains into IF/ID first cycle stall=0.
//  IF/ID update when stall=0 and no delivery: if_id_valid<=0, if_id_inst<=NOP_INST (bubble).
//  Decode redirect: if_id_valid & opcode in {1100011,1101111,1100111} & prediction & !stall ->
//   fetch_pc<=new_pc; skid cleared; S_WAIT->S_DROP, else S_ISSUE; IF/ID advances with bubble.
//  Mispredict: res_valid & (res_taken != res_pred) -> fetch_pc<= res_taken ? res_target : res_pc+4;
//   flush=1 next cycle only; IF/ID<=bubble; skid cleared; S_WAIT->S_DROP (response in the same cycle is
//   also dropped), else S_ISSUE. Overrides stall and decode redirect.
//  Priority: rst > mispredict > stall > decode redirect > sequential (+4, 32-bit wrap, no trap).
//  Accept and redirect in the same cycle: request still goes out, response dropped (S_DROP).
//  Latency: accept at cycle N, imem_valid at N+k -> if_id valid at N+k+1.
// CONFIGURATION
//  MISPRED_CNT_EN defined: mispred_cnt increments (wraps) on each mispredict; cleared by rst only.
//  Undefined: counter logic absent, mispred_cnt tied to 32'h0. No other behaviour differs.
// STRUCTURE
//  Shared package fetch_pkg: opcode constants (BRANCH/JAL/JALR), NOP_INST, fetch_state_t enum
//  {S_BOOT,S_ISSUE,S_WAIT,S_DROP}. One sub-module: fetch_skid_buf (1-entry pc+inst buffer,
//  push/pop/clear, full flag). Top: FSM, PC mux, IF/ID register, optional counter.
// TESTING
//  Reset, 1-cycle memory, 8 sequential fetches -> if_id_pc 0,4,..,28, valid each 2 cycles, no flush.
//  Stall held 3 cycles while response returns -> IF/ID frozen, inst in skid, delivered on stall drop, no loss.
//  IF/ID=beq (0x00000063) at pc 0x10, prediction=1, new_pc=0x40 -> pc 0x14 dropped, next valid pc 0x40.
//  res_valid, res_pred=1, res_taken=0, res_pc=0x40 -> flush 1 cycle, next if_id_pc 0x44, cnt=1 if EN.
//  Mispredict with stall=1 and decode redirect same cycle -> mispredict target wins, stall ignored.
//  rst asserted in S_WAIT, response arrives during rst -> dropped, first fetch after release at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: control-flow opcodes,
// the bubble instruction and the fetch FSM state type.
package fetch_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_ISSUE,
    S_WAIT,
    S_DROP
  } fetch_state_t;

  function automatic logic is_ctrl_op(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc/inst holding buffer for a fetch response that arrives while
// IF/ID cannot accept it. Clear wins over push, push over pop.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] inst
);
  import fetch_pkg::*;

  // Buffer occupancy and payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      pc   <= '0;
      inst <= NOP_INST;
    end else if (clear) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      pc   <= push_pc;
      inst <= push_inst;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, single-outstanding imem handshake,
// IF/ID register, decode-time redirect and mispredict recovery.
// Optional feature: define MISPRED_CNT_EN to enable the mispredict counter;
// otherwise mispred_cnt is tied to zero.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        prediction,
  input  logic [31:0] new_pc,
  input  logic        res_valid,
  input  logic        res_pred,
  input  logic        res_taken,
  input  logic [31:0] res_pc,
  input  logic [31:0] res_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        flush,
  output logic [31:0] mispred_cnt
);
  import fetch_pkg::*;

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic         skid_full;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_inst;
  logic         accept;
  logic         mispredict;
  logic [31:0]  mispredict_pc;
  logic         redirect;
  logic         squash;
  logic         deliver;
  logic         load_fetch;
  logic         skid_push;
  logic         skid_pop;

  assign imem_req      = (state == S_ISSUE) && !skid_full;
  assign imem_addr     = fetch_pc;
  assign accept        = imem_req && imem_ready;
  assign mispredict    = res_valid && (res_taken != res_pred);
  assign mispredict_pc = res_taken ? res_target : res_pc + 32'd4;
  assign redirect      = if_id_valid && is_ctrl_op(if_id_inst[6:0]) && prediction
                         && !stall && !mispredict;
  assign squash        = mispredict || redirect;
  // A response coinciding with a redirect belongs to the wrong path.
  assign deliver       = (state == S_WAIT) && imem_valid && !squash;
  assign load_fetch    = deliver && !stall && !skid_full;
  assign skid_push     = deliver && !load_fetch;
  assign skid_pop      = skid_full && !stall && !squash;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .pop       (skid_pop),
    .clear     (squash),
    .push_pc   (fetch_pc),
    .push_inst (imem_rdata),
    .full      (skid_full),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  // Fetch FSM, PC selection and flush pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      flush    <= 1'b0;
    end else begin
      flush <= mispredict;
      if (mispredict)    fetch_pc <= mispredict_pc;
      else if (redirect) fetch_pc <= new_pc;
      else if (deliver)  fetch_pc <= fetch_pc + 32'd4;
      case (state)
        S_BOOT:  state <= S_ISSUE;
        S_ISSUE: if (accept) state <= squash ? S_DROP : S_WAIT;
        // A response in the squash cycle is consumed (dropped), so no S_DROP is needed.
        S_WAIT:  if (imem_valid) state <= S_ISSUE;
                 else if (squash) state <= S_DROP;
        S_DROP:  if (imem_valid) state <= S_ISSUE;
      endcase
    end
  end

  // IF/ID register: skid drains first, then direct delivery, else bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc    <= '0;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (squash) begin
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (skid_pop) begin
        if_id_pc    <= skid_pc;
        if_id_inst  <= skid_inst;
        if_id_valid <= 1'b1;
      end else if (load_fetch) begin
        if_id_pc    <= fetch_pc;
        if_id_inst  <= imem_rdata;
        if_id_valid <= 1'b1;
      end else begin
        if_id_inst  <= NOP_INST;
        if_id_valid <= 1'b0;
      end
    end
  end

`ifdef MISPRED_CNT_EN
  // Wrapping mispredict counter, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             mispred_cnt <= '0;
    else if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
  end
`else
  assign mispred_cnt = '0;
`endif

endmodule
